// File: rtl/tmds_rx_word_align.sv
// TMDS receive word aligner: builds 10-bit characters from 5-bit
// deserializer words and hunts all bit offsets for control-token runs.
module tmds_rx_word_align #(
    parameter int TOKEN_RUN    = 8,
    parameter int SEARCH_CHARS = 4096,
    parameter int LOSS_CHARS   = 8192
) (
    input  logic       gclk,
    input  logic       reset_n,
    input  logic [4:0] datain,
    output logic [9:0] dataout,
    output logic       dataout_valid,
    output logic       token_det,
    output logic       locked,
    output logic [3:0] bit_offset
);
    localparam int MAX_CHARS =
        (SEARCH_CHARS > LOSS_CHARS) ? SEARCH_CHARS : LOSS_CHARS;
    localparam int CW = $clog2(MAX_CHARS) + 1;
    localparam int RW = $clog2(TOKEN_RUN + 1);

    localparam logic [CW-1:0] SRCH_LAST = CW'(SEARCH_CHARS - 1);
    localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_CHARS - 1);
    localparam logic [RW-1:0] RUN_FULL  = RW'(TOKEN_RUN);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic [14:0]   hist_q;
    logic [19:0]   hist_d;
    logic          phase_q;
    logic [9:0]    dout_q;
    logic          valid_q;
    logic          tok_q;
    logic [9:0]    win;
    logic          win_tok;
    logic          char_ev;
    logic          locked_q, locked_d;
    logic [3:0]    off_q, off_d;
    logic [RW-1:0] run_q, run_d, run_inc;
    logic [CW-1:0] cnt_q, cnt_d;

    // Only the newest three words are kept: a window never reaches the fourth.
    assign hist_d  = {datain, hist_q};
    assign char_ev = phase_q;

    always_comb begin
        win = hist_d[9:0];
        for (int i = 1; i < 10; i++) begin
            if (off_q == 4'(i)) begin
                win = hist_d[i +: 10];
            end
        end
    end

    assign win_tok = (win == 10'h354) || (win == 10'h0AB) ||
                     (win == 10'h154) || (win == 10'h2AB);

    assign run_inc = (run_q == RUN_FULL) ? run_q : run_q + RW'(1);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        locked_d = locked_q;
        if (char_ev) begin
            unique case (state_q)
                ST_SEARCH: begin
                    run_d = win_tok ? run_inc : '0;
                    if (win_tok && (run_inc == RUN_FULL)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q == SRCH_LAST) begin
                        state_d = ST_SLIP;
                        off_d   = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
                        run_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SLIP: begin
                    // First character at the new offset is not counted.
                    state_d = ST_SEARCH;
                    run_d   = '0;
                    cnt_d   = '0;
                end
                ST_LOCKED: begin
                    run_d = win_tok ? run_inc : '0;
                    if (win_tok) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOSS_LAST) begin
                        state_d  = ST_SEARCH;
                        locked_d = 1'b0;
                        run_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge gclk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q   <= '0;
            phase_q  <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            tok_q    <= 1'b0;
            state_q  <= ST_SEARCH;
            run_q    <= '0;
            cnt_q    <= '0;
            off_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            hist_q   <= hist_d[19:5];
            phase_q  <= ~phase_q;
            valid_q  <= char_ev;
            if (char_ev) begin
                dout_q <= win;
                tok_q  <= win_tok;
            end
            state_q  <= state_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            locked_q <= locked_d;
        end
    end

    assign dataout       = dout_q;
    assign dataout_valid = valid_q;
    assign token_det     = tok_q;
    assign locked        = locked_q;
    assign bit_offset    = off_q;

endmodule
